keypad_key_fifo: RTL and testbench

KEYPAD_KEY_FIFO -- requirements
Module: keypad_key_fifo

---
 rtl/keypad_key_fifo_if.sv | 33 +++
 rtl/keypad_key_fifo.sv | 157 +++++++++++++++
 tb/tb_keypad_key_fifo.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_key_fifo_if.sv
// Keypad key FIFO bus interface.
// Groups the key input, read/clear strobes and the FIFO status outputs.
//   key_in   : ASCII code from the scanner (0 = no key / ambiguous)
//   rd       : pop strobe, acts only while valid=1
//   clr_ovf  : clears the sticky overflow flag
//   data_out : head entry (show-ahead), 0 when empty
//   valid    : FIFO non-empty
//   count    : number of occupied entries
//   overflow : sticky flag, a qualified key was dropped while full
// master = the key source / reader, slave = the key FIFO block.
interface keypad_key_fifo_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    key_in;
  logic          rd;
  logic          clr_ovf;
  logic [7:0]    data_out;
  logic          valid;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output key_in, rd, clr_ovf,
    input  data_out, valid, count, overflow
  );

  modport slave (
    input  key_in, rd, clr_ovf,
    output data_out, valid, count, overflow
  );
endinterface

// File: rtl/keypad_key_fifo.sv
// Keypad key debouncer feeding a show-ahead key FIFO.
// A key code must be seen unchanged for DEBOUNCE consecutive clocks before it
// is pushed once; it must then be released (0) for DEBOUNCE clocks before a new
// press can be accepted, so holding a key never auto-repeats.
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset
//   bus : keypad_key_fifo_if slave modport (key_in, rd, clr_ovf in;
//         data_out, valid, count, overflow out)
// All outputs come from registered state only; key_in and rd reach no output
// combinationally.
module keypad_key_fifo #(
  parameter int DEBOUNCE = 16,
  parameter int DEPTH    = 8
) (
  input  logic            clk,
  input  logic            rst,
  keypad_key_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [16:0]   DB_TARGET = 17'(DEBOUNCE);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t      state;
  logic [7:0]  cand;
  logic [15:0] cnt;

  logic [16:0] cnt_inc;
  logic        cnt_done;
  logic        key_zero;
  logic        key_match;
  logic        press_done;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] count_q;
  logic          ovf_q;

  logic valid;
  logic full;
  logic pop;
  logic push;
  logic ovf_set;

  // One extra bit so the "would reach DEBOUNCE" test cannot wrap.
  assign cnt_inc   = {1'b0, cnt} + 17'd1;
  assign cnt_done  = (cnt_inc == DB_TARGET);
  assign key_zero  = (bus.key_in == 8'd0);
  assign key_match = (bus.key_in == cand);

  // cand is never 0 in PRESS_WAIT, so a match implies a nonzero key.
  assign press_done = (state == PRESS_WAIT) && key_match && cnt_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cand  <= 8'd0;
      cnt   <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!key_zero) begin
            cand  <= bus.key_in;
            cnt   <= 16'd1;
            state <= PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (key_zero) begin
            state <= IDLE;
          end else if (key_match) begin
            if (cnt_done) begin
              state <= HELD;
            end else begin
              cnt <= cnt_inc[15:0];
            end
          end else begin
            // A different code restarts qualification with the new code.
            cand <= bus.key_in;
            cnt  <= 16'd1;
          end
        end
        HELD: begin
          if (key_zero) begin
            cnt   <= 16'd1;
            state <= RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (!key_zero) begin
            state <= HELD;
          end else if (cnt_done) begin
            state <= IDLE;
          end else begin
            cnt <= cnt_inc[15:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign valid = (count_q != '0);
  assign full  = (count_q == FULL_CNT);
  assign pop   = bus.rd && valid;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push    = press_done && (!full || pop);
  assign ovf_set = press_done && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        wp <= wp + AW'(1);
      end
      if (pop) begin
        rp <= rp + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // Set has priority over a clear on the same edge.
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Storage is not reset; emptying the pointers discards its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= cand;
    end
  end

  assign bus.valid    = valid;
  assign bus.data_out = valid ? mem[rp] : 8'd0;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_keypad_key_fifo.sv
// Testbench for keypad_key_fifo (DEBOUNCE=4, DEPTH=8).
// A per-cycle vector table covers a single press and a bounce; hand-written
// sequences use a queue model of the FIFO for overflow, push/pop collision,
// re-press during release and reset behaviour.
module tb_keypad_key_fifo;
  localparam int DB    = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;

  keypad_key_fifo_if #(.DEPTH(DEPTH)) bus ();

  keypad_key_fifo #(
    .DEBOUNCE(DB),
    .DEPTH   (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] key;
    logic       rd;
    logic       clr;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_count;
    logic       exp_ovf;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];
  logic       ovf_m;
  int         errors = 0;
  int         checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [7:0] key, input logic rd, input logic clr,
                         input logic v, input logic [7:0] d, input int c, input logic o);
    vec_t r;
    r.key = key; r.rd = rd; r.clr = clr;
    r.exp_valid = v; r.exp_data = d; r.exp_count = c; r.exp_ovf = o;
    vecs.push_back(r);
  endtask

  task automatic check_model(input string tag);
    chk({tag, " count"}, int'(bus.count), sb.size());
    chk({tag, " valid"}, int'(bus.valid), (sb.size() != 0) ? 1 : 0);
    chk({tag, " data_out"}, int'(bus.data_out), (sb.size() != 0) ? int'(sb[0]) : 0);
    chk({tag, " overflow"}, int'(bus.overflow), int'(ovf_m));
  endtask

  // Stable press for DB cycles (push on the last), then a full release.
  task automatic press(input logic [7:0] code, input bit rd_at_push, input bit clr_at_push);
    bit dropped;
    for (int i = 0; i < DB; i++) begin
      bus.key_in = code;
      if (i == DB - 1) begin
        bus.rd      = rd_at_push;
        bus.clr_ovf = clr_at_push;
        if (rd_at_push && sb.size() > 0) begin
          chk("head at collision", int'(bus.data_out), int'(sb[0]));
          void'(sb.pop_front());
        end
        dropped = 1'b0;
        if (sb.size() < DEPTH) sb.push_back(code);
        else begin
          ovf_m   = 1'b1;
          dropped = 1'b1;
        end
        if (clr_at_push && !dropped) ovf_m = 1'b0;
      end
      tick();
      if (i == DB - 2) chk("no early push", int'(bus.count), sb.size());
      bus.rd      = 1'b0;
      bus.clr_ovf = 1'b0;
    end
    bus.key_in = 8'd0;
    repeat (DB) tick();
  endtask

  task automatic read_one();
    chk("read data", int'(bus.data_out), int'(sb[0]));
    void'(sb.pop_front());
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.key_in  = 8'd0;
    bus.rd      = 1'b0;
    bus.clr_ovf = 1'b0;
    ovf_m       = 1'b0;
    rst         = 1'b1;
    repeat (2) tick();
    check_model("reset");
    rst = 1'b0;

    // Single press of '1' held 10 cycles, release, read; then a bounce.
    for (int i = 0; i < 10; i++)
      add_vec(8'd49, 1'b0, 1'b0, i >= 3, (i >= 3) ? 8'd49 : 8'd0, (i >= 3) ? 1 : 0, 1'b0);
    for (int i = 0; i < 4; i++)
      add_vec(8'd0, 1'b0, 1'b0, 1'b1, 8'd49, 1, 1'b0);
    add_vec(8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 0, 1'b0);
    add_vec(8'd49, 1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0);
    add_vec(8'd49, 1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0);
    add_vec(8'd0,  1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0);
    add_vec(8'd52, 1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0);
    add_vec(8'd52, 1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      add_vec(8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0);

    foreach (vecs[i]) begin
      bus.key_in  = vecs[i].key;
      bus.rd      = vecs[i].rd;
      bus.clr_ovf = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d valid", i), int'(bus.valid), int'(vecs[i].exp_valid));
      chk($sformatf("vec%0d data_out", i), int'(bus.data_out), int'(vecs[i].exp_data));
      chk($sformatf("vec%0d count", i), int'(bus.count), vecs[i].exp_count);
      chk($sformatf("vec%0d overflow", i), int'(bus.overflow), int'(vecs[i].exp_ovf));
    end
    bus.rd = 1'b0;

    // Nine presses with no reads: the ninth overflows.
    for (int c = 49; c <= 57; c++) press(8'(c), 1'b0, 1'b0);
    check_model("nine presses");
    // Clear coinciding with an overflowing push: set wins.
    press(8'd48, 1'b0, 1'b1);
    check_model("clr vs set");
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    ovf_m = 1'b0;
    check_model("clr_ovf");
    repeat (DEPTH) read_one();
    check_model("drained");
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    check_model("rd while empty");

    // Full FIFO, push and pop on the same edge.
    for (int c = 49; c <= 56; c++) press(8'(c), 1'b0, 1'b0);
    check_model("full");
    press(8'd57, 1'b1, 1'b0);
    check_model("full push+pop");
    repeat (DEPTH) read_one();
    check_model("collision drained");

    // Press '5', short release, re-press: a single push.
    for (int i = 0; i < DB; i++) begin
      bus.key_in = 8'd53;
      if (i == DB - 1) sb.push_back(8'd53);
      tick();
    end
    bus.key_in = 8'd0;
    repeat (2) tick();
    bus.key_in = 8'd53;
    repeat (3 * DB) tick();
    check_model("re-press held");
    bus.key_in = 8'd0;
    repeat (DB) tick();
    check_model("re-press released");
    read_one();
    check_model("re-press drained");

    // Three entries with overflow set, then a one-edge reset.
    for (int c = 49; c <= 57; c++) press(8'(c), 1'b0, 1'b0);
    repeat (5) read_one();
    check_model("pre-reset");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    ovf_m = 1'b0;
    check_model("after reset");
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    check_model("rd after reset");

    // Key held through reset release is debounced from the first free edge.
    bus.key_in = 8'd49;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (DB - 1) tick();
    check_model("held through reset pre-push");
    tick();
    sb.push_back(8'd49);
    check_model("held through reset push");
    bus.key_in = 8'd0;
    repeat (DB) tick();
    read_one();
    check_model("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
